sw_test_term_ctrl: RTL and testbench

// - Sequences Verilator simulation termination from the SW test status word written to sim SRAM.
// - Sits in the chip-level Verilator testbench between sim_sram's write monitor and the $finish logic.
// - Captures the verdict, then waits for the UART DPI to drain before raising done.
// - Optional watchdog ends hung tests.

---
 rtl/sw_test_term_ctrl_if.sv | 22 ++
 rtl/sw_test_term_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_sw_test_term_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sw_test_term_ctrl_if.sv
// -----------------------------------------------------------------------------
// sw_test_term_ctrl_if
//   Write-monitor bus tapped from the simulation SRAM. One beat per cycle;
//   there is no back-pressure, a write is simply observed when wr_valid is 1.
//
//   Signals
//     wr_valid  1   write strobe
//     addr      32  write address
//     data      16  write data [15:0]
//
//   Modports
//     master  drives the bus (SRAM write monitor / testbench)
//     slave   observes the bus (sw_test_term_ctrl)
// -----------------------------------------------------------------------------
interface sw_test_term_ctrl_if;
  logic        wr_valid;
  logic [31:0] addr;
  logic [15:0] data;

  modport master (output wr_valid, output addr, output data);
  modport slave  (input  wr_valid, input  addr, input  data);
endinterface : sw_test_term_ctrl_if

// File: rtl/sw_test_term_ctrl.sv
// -----------------------------------------------------------------------------
// sw_test_term_ctrl
//   Decides when a Verilator chip-level simulation may end. Software writes a
//   16-bit status word to a fixed SRAM address. A "test started" code moves
//   the FSM to Running. A pass or fail code latches the verdict and moves it
//   to Drain. Drain waits for the UART DPI FIFO to stay idle for DrainCycles
//   consecutive cycles, so the final console text is printed before $finish.
//   The FSM then enters Done, which is sticky until reset.
//
//   Optional feature: define SW_TEST_TIMEOUT_EN to enable a watchdog. The
//   watchdog forces Done with a fail verdict after TimeoutCycles cycles spent
//   in Idle/Running. When the macro is undefined there is no watchdog logic
//   and timeout_o is tied to 0.
//
//   Ports
//     clk_i           in   1   clock, all state updates on posedge
//     rst_i           in   1   synchronous active-high reset
//     sram_wr         slave    SRAM write monitor (wr_valid / addr / data)
//     status_addr_i   in   32  address of the status word (quasi-static)
//     uart_tx_idle_i  in   1   UART TX idle / DPI FIFO empty
//     status_o        out  16  last accepted status word
//     state_o         out  2   0 Idle, 1 Running, 2 Drain, 3 Done
//     done_o          out  1   termination request, sticky until reset
//     passed_o        out  1   verdict, valid only while done_o=1
//     timeout_o       out  1   Done was reached through the watchdog
// -----------------------------------------------------------------------------
module sw_test_term_ctrl #(
  parameter int unsigned DrainCycles   = 1024,
  parameter int unsigned TimeoutCycles = 32'd5_000_000,
  parameter logic [15:0] StatusInTest  = 16'h4354,
  parameter logic [15:0] StatusPassed  = 16'h900d,
  parameter logic [15:0] StatusFailed  = 16'hbaad
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  sw_test_term_ctrl_if.slave         sram_wr,
  input  logic [31:0]                status_addr_i,
  input  logic                       uart_tx_idle_i,
  output logic [15:0]                status_o,
  output logic [1:0]                 state_o,
  output logic                       done_o,
  output logic                       passed_o,
  output logic                       timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // A zero-length drain still needs a 1-bit counter so the vector is legal.
  localparam int unsigned DrainW = (DrainCycles == 0) ? 1 : $clog2(DrainCycles + 1);
  localparam logic [DrainW-1:0] DrainMax = DrainW'(DrainCycles);

  state_e            state_q, state_d;
  logic [15:0]       status_q, status_d;
  logic              verdict_q, verdict_d;
  logic              timeout_q, timeout_d;
  logic [DrainW-1:0] drain_cnt_q;

  logic hit;
  logic code_pass;
  logic code_fail;
  logic drain_last;
  logic wd_expire;

  assign hit       = sram_wr.wr_valid && (sram_wr.addr == status_addr_i);
  assign code_pass = (sram_wr.data == StatusPassed);
  assign code_fail = (sram_wr.data == StatusFailed);

  // Last Drain cycle: the counter has seen DrainCycles-1 idle cycles and the
  // current one is idle too. A zero-length drain leaves after one cycle.
  generate
    if (DrainCycles == 0) begin : g_drain_zero
      assign drain_last = 1'b1;
    end else begin : g_drain_cnt
      assign drain_last = uart_tx_idle_i && (drain_cnt_q == DrainW'(DrainCycles - 1));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Drain counter: runs only in Drain, any non-idle cycle restarts the count,
  // and it saturates at DrainCycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state is assigned with <= only, so every register
      // samples the pre-edge values of the others regardless of block order.
      drain_cnt_q <= '0;
    end else if (state_q != ST_DRAIN || !uart_tx_idle_i) begin
      drain_cnt_q <= '0;
    end else if (drain_cnt_q != DrainMax) begin
      drain_cnt_q <= drain_cnt_q + 1'b1;
    end
  end

`ifdef SW_TEST_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: counts cycles spent waiting for a verdict, freezes once a
  // verdict or timeout has been reached, and never wraps.
  // ---------------------------------------------------------------------------
  localparam int unsigned WdW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);

  logic [WdW-1:0] wd_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if ((state_q == ST_IDLE || state_q == ST_RUNNING) && wd_cnt_q != WdMax) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  generate
    if (TimeoutCycles == 0) begin : g_wd_zero
      assign wd_expire = 1'b1;
    end else begin : g_wd_cnt
      assign wd_expire = (wd_cnt_q == WdW'(TimeoutCycles - 1));
    end
  endgenerate
`else
  assign wd_expire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      status_q  <= '0;
      verdict_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      verdict_q <= verdict_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_d   = state_q;
    status_d  = status_q;
    verdict_d = verdict_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          status_d = sram_wr.data;
          if (sram_wr.data == StatusInTest) begin
            state_d = ST_RUNNING;
          end else if (code_pass || code_fail) begin
            // Boot-stage software can report a verdict without InTest first.
            state_d   = ST_DRAIN;
            verdict_d = code_pass;
          end
        end
      end

      ST_RUNNING: begin
        if (hit) begin
          status_d = sram_wr.data;
          if (code_pass || code_fail) begin
            state_d   = ST_DRAIN;
            verdict_d = code_pass;
          end
        end
      end

      ST_DRAIN: begin
        // Writes are ignored here: the verdict is already latched.
        if (drain_last) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog expiry ends the test unless a verdict arrives the same cycle;
    // a real verdict always beats a timeout.
    if ((state_q == ST_IDLE || state_q == ST_RUNNING) && wd_expire &&
        state_d != ST_DRAIN) begin
      state_d   = ST_DONE;
      verdict_d = 1'b0;
      timeout_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs, decoded from registers only
  // ---------------------------------------------------------------------------
  always_comb begin
    state_o   = state_q;
    status_o  = status_q;
    done_o    = (state_q == ST_DONE);
    passed_o  = (state_q == ST_DONE) && verdict_q;
    timeout_o = timeout_q;
  end

endmodule : sw_test_term_ctrl

// File: tb/tb_sw_test_term_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_test_term_ctrl
//   Directed bench for sw_test_term_ctrl. Three instances share one SRAM write
//   bus and are exercised one at a time while the others are held in reset:
//     u_dut_a  DrainCycles=4
//     u_dut_b  DrainCycles=8
//     u_dut_c  DrainCycles=2, TimeoutCycles=100
//   Timing: inputs change 1 ns after a rising edge; outputs are sampled at the
//   same point, so after each cyc() they show the state of the new cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sw_test_term_ctrl;

`ifdef SW_TEST_TIMEOUT_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  localparam logic [31:0] StatusAddr = 32'h0000_1000;
  localparam logic [15:0] InTest     = 16'h4354;
  localparam logic [15:0] Passed     = 16'h900d;
  localparam logic [15:0] Failed     = 16'hbaad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        idle_a, idle_b, idle_c;
  logic [31:0] status_addr;

  logic [15:0] status_a, status_b, status_c;
  logic [1:0]  state_a, state_b, state_c;
  logic        done_a, done_b, done_c;
  logic        passed_a, passed_b, passed_c;
  logic        timeout_a, timeout_b, timeout_c;

  int n_vec = 0;
  int n_err = 0;

  sw_test_term_ctrl_if bus ();

  sw_test_term_ctrl #(.DrainCycles(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .sram_wr(bus.slave), .status_addr_i(status_addr),
    .uart_tx_idle_i(idle_a), .status_o(status_a), .state_o(state_a),
    .done_o(done_a), .passed_o(passed_a), .timeout_o(timeout_a)
  );

  sw_test_term_ctrl #(.DrainCycles(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .sram_wr(bus.slave), .status_addr_i(status_addr),
    .uart_tx_idle_i(idle_b), .status_o(status_b), .state_o(state_b),
    .done_o(done_b), .passed_o(passed_b), .timeout_o(timeout_b)
  );

  sw_test_term_ctrl #(.DrainCycles(2), .TimeoutCycles(100)) u_dut_c (
    .clk_i(clk), .rst_i(rst_c), .sram_wr(bus.slave), .status_addr_i(status_addr),
    .uart_tx_idle_i(idle_c), .status_o(status_c), .state_o(state_c),
    .done_o(done_c), .passed_o(passed_c), .timeout_o(timeout_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One write beat; on return the DUT has sampled it.
  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    bus.wr_valid = 1'b1;
    bus.addr     = a;
    bus.data     = d;
    cyc(1);
    bus.wr_valid = 1'b0;
    bus.addr     = '0;
    bus.data     = '0;
  endtask

  task automatic check_a(input string tag, input logic [1:0] st, input logic [15:0] sts,
                         input logic dn, input logic ps);
    check({tag, ".state"},   state_a,   st);
    check({tag, ".status"},  status_a,  sts);
    check({tag, ".done"},    done_a,    dn);
    check({tag, ".passed"},  passed_a,  ps);
    check({tag, ".timeout"}, timeout_a, 1'b0);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.addr     = '0;
    bus.data     = '0;
    status_addr  = StatusAddr;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    idle_a = 1'b1; idle_b = 1'b1; idle_c = 1'b1;
    cyc(2);

    // ---- reset state of all instances ----
    check_a("rst_a", 2'd0, 16'h0, 1'b0, 1'b0);
    check("rst_b.state", state_b, 2'd0);
    check("rst_b.done",  done_b,  1'b0);
    check("rst_c.state", state_c, 2'd0);
    check("rst_c.timeout", timeout_c, 1'b0);

    // ---- A: pass sequence with filters ----
    rst_a = 1'b0;
    wr(StatusAddr, 16'h1234);                 // unknown code: status only
    check_a("idle_other", 2'd0, 16'h1234, 1'b0, 1'b0);
    wr(StatusAddr, InTest);
    check_a("intest", 2'd1, InTest, 1'b0, 1'b0);
    wr(StatusAddr + 32'd4, Passed);           // wrong address
    check_a("addr_filter", 2'd1, InTest, 1'b0, 1'b0);
    wr(StatusAddr, InTest);                   // repeated InTest stays Running
    check_a("intest_again", 2'd1, InTest, 1'b0, 1'b0);
    wr(StatusAddr, Passed);                   // written in cycle N, now N+1
    check_a("pass_drain", 2'd2, Passed, 1'b0, 1'b0);
    cyc(3);                                   // cycle N+4
    check_a("pass_n4", 2'd2, Passed, 1'b0, 1'b0);
    cyc(1);                                   // cycle N+5
    check_a("pass_done", 2'd3, Passed, 1'b1, 1'b1);
    wr(StatusAddr, Failed);                   // ignored in Done
    check_a("done_filter", 2'd3, Passed, 1'b1, 1'b1);
    cyc(3);
    check_a("done_sticky", 2'd3, Passed, 1'b1, 1'b1);

    // ---- A: fail from Idle, later pass write cannot change verdict ----
    rst_a = 1'b1; cyc(1); rst_a = 1'b0;
    check_a("rst_after_done", 2'd0, 16'h0, 1'b0, 1'b0);
    wr(StatusAddr, Failed);
    check_a("fail_idle", 2'd2, Failed, 1'b0, 1'b0);
    wr(StatusAddr, Passed);                   // ignored in Drain
    check_a("drain_filter", 2'd2, Failed, 1'b0, 1'b0);
    cyc(3);
    check_a("fail_done", 2'd3, Failed, 1'b1, 1'b0);

    // ---- A: reset mid-Drain, then a fresh pass completes ----
    rst_a = 1'b1; cyc(1); rst_a = 1'b0;
    wr(StatusAddr, InTest);
    wr(StatusAddr, Passed);
    cyc(2);
    check_a("pre_mid_rst", 2'd2, Passed, 1'b0, 1'b0);
    rst_a = 1'b1; cyc(1); rst_a = 1'b0;
    check_a("mid_rst", 2'd0, 16'h0, 1'b0, 1'b0);
    wr(StatusAddr, InTest);
    wr(StatusAddr, Passed);
    cyc(3);
    check_a("fresh_n4", 2'd2, Passed, 1'b0, 1'b0);
    cyc(1);
    check_a("fresh_done", 2'd3, Passed, 1'b1, 1'b1);
    rst_a = 1'b1;

    // ---- B: drain restart (DrainCycles=8) ----
    rst_b = 1'b0;
    wr(StatusAddr, InTest);
    wr(StatusAddr, Passed);                   // now cycle N+1
    check("rst.b_drain", state_b, 2'd2);
    cyc(5);                                   // 5 idle cycles seen, now N+6
    idle_b = 1'b0;
    cyc(1);                                   // counter cleared, now N+7
    idle_b = 1'b1;
    check("restart.state", state_b, 2'd2);
    check("restart.done",  done_b,  1'b0);
    cyc(7);                                   // 7 further idle cycles
    check("restart.n14_done", done_b, 1'b0);
    cyc(1);                                   // 8th idle cycle done
    check("restart.done_now", done_b,   1'b1);
    check("restart.passed",   passed_b, 1'b1);
    check("restart.state3",   state_b,  2'd3);
    rst_b = 1'b1;

    // ---- C: watchdog expiry with no verdict ----
    rst_c = 1'b0;                             // now cycle 0
    cyc(99);                                  // cycle 99
    check("wd.c99_done", done_c, 1'b0);
    cyc(1);                                   // cycle 100
    check("wd.c100_done",    done_c,    WdEn);
    check("wd.c100_timeout", timeout_c, WdEn);
    check("wd.c100_passed",  passed_c,  1'b0);
    check("wd.c100_state",   state_c,   WdEn ? 2'd3 : 2'd0);

    // ---- C: pass hit on expiry cycle wins ----
    rst_c = 1'b1; cyc(1); rst_c = 1'b0;       // cycle 0
    cyc(99);                                  // cycle 99
    wr(StatusAddr, Passed);                   // sampled on the expiry cycle
    check("wd_race.state",   state_c,   2'd2);
    check("wd_race.timeout", timeout_c, 1'b0);
    cyc(1);
    check("wd_race.n1_done", done_c, 1'b0);
    cyc(1);
    check("wd_race.done",    done_c,    1'b1);
    check("wd_race.passed",  passed_c,  1'b1);
    check("wd_race.timeout2", timeout_c, 1'b0);
    rst_c = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sw_test_term_ctrl
